// File: rtl/tlp_tx_arb.sv
// tlp_tx_arb: packet-granular round-robin arbiter merging several TLP sources
// onto one 64-bit PCIe TX stream. An owner keeps the stream until its EOP beat
// transfers; source 0 can optionally pre-empt the round-robin group at packet
// boundaries.
//
// state  | meaning
// S_IDLE | no owner; all ready/valid outputs low, arbitration each cycle
// S_LOCK | owner in grant_out forwards beats until its EOP transfers
module tlp_tx_arb #(
    parameter int NUM_SRC = 3,
    parameter int HIPRI0  = 1,
    parameter int MAX_QWS = 18,
    localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int CW = $clog2(MAX_QWS + 1)
) (
    input  logic                  pcieClk_in,
    input  logic                  reset_in,
    input  logic [NUM_SRC*64-1:0] srcData_in,
    input  logic [NUM_SRC-1:0]    srcValid_in,
    input  logic [NUM_SRC-1:0]    srcSOP_in,
    input  logic [NUM_SRC-1:0]    srcEOP_in,
    output logic [NUM_SRC-1:0]    srcReady_out,
    output logic [63:0]           txData_out,
    output logic                  txValid_out,
    output logic                  txSOP_out,
    output logic                  txEOP_out,
    input  logic                  txReady_in,
    output logic [GW-1:0]         grant_out,
    output logic                  busy_out,
    output logic                  errLen_out,
    output logic                  errSop_out
);

    typedef enum logic {S_IDLE, S_LOCK} state_t;

    localparam logic [GW-1:0] RR_INIT = (HIPRI0 != 0) ? GW'(1) : GW'(0);

    state_t          state;
    logic [GW-1:0]   rr_ptr;
    logic [CW-1:0]   qw_cnt;
    logic [NUM_SRC-1:0] elig;
    logic            sel_found;
    logic [GW-1:0]   sel_idx;
    logic            lock;
    logic [63:0]     own_data;
    logic            own_valid;
    logic            own_sop;
    logic            own_eop;
    logic            xfer;

    // base + k, wrapped into 0..NUM_SRC-1 (k never exceeds NUM_SRC-1)
    function automatic logic [GW-1:0] rr_index(input logic [GW-1:0] base, input int k);
        int v;
        v = int'(base) + k;
        if (v >= NUM_SRC) v = v - NUM_SRC;
        return GW'(v);
    endfunction

    // Pointer after granting g; source 0 is never a round-robin slot under HIPRI0
    function automatic logic [GW-1:0] rr_next(input logic [GW-1:0] g);
        int v;
        v = int'(g) + 1;
        if (v >= NUM_SRC) v = 0;
        if (HIPRI0 != 0 && v == 0) v = 1;
        return GW'(v);
    endfunction

    assign elig = srcValid_in & srcSOP_in;
    assign lock = (state == S_LOCK);
    assign busy_out = lock;

    // Winner for this idle cycle: strict source 0 first, else scan up from rr_ptr
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        if (HIPRI0 != 0 && elig[0]) begin
            sel_found = 1'b1;
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (!sel_found && elig[rr_index(rr_ptr, k)] &&
                    !(HIPRI0 != 0 && rr_index(rr_ptr, k) == '0)) begin
                    sel_found = 1'b1;
                    sel_idx   = rr_index(rr_ptr, k);
                end
            end
        end
    end

    // Owner mux; valid/SOP/EOP are gated so nothing leaks out while idle
    always_comb begin
        own_data     = srcData_in[int'(grant_out)*64 +: 64];
        own_valid    = srcValid_in[grant_out];
        own_sop      = srcSOP_in[grant_out];
        own_eop      = srcEOP_in[grant_out];
        txData_out   = own_data;
        txValid_out  = lock & own_valid;
        txSOP_out    = lock & own_sop;
        txEOP_out    = lock & own_eop;
        srcReady_out = '0;
        if (lock) srcReady_out[grant_out] = txReady_in;
    end

    assign xfer = txValid_out & txReady_in;

    // Arbitration FSM, beat counting and sticky framing errors
    always_ff @(posedge pcieClk_in or posedge reset_in) begin
        if (reset_in) begin
            state      <= S_IDLE;
            grant_out  <= '0;
            qw_cnt     <= '0;
            rr_ptr     <= RR_INIT;
            errLen_out <= 1'b0;
            errSop_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|(srcValid_in & ~srcSOP_in)) errSop_out <= 1'b1;
                    if (sel_found) begin
                        state     <= S_LOCK;
                        grant_out <= sel_idx;
                        qw_cnt    <= '0;
                        if (!(HIPRI0 != 0 && sel_idx == '0)) rr_ptr <= rr_next(sel_idx);
                    end
                end
                S_LOCK: begin
                    if (xfer) begin
                        if (qw_cnt == CW'(MAX_QWS)) errLen_out <= 1'b1;
                        else qw_cnt <= qw_cnt + 1'b1;
                        if (own_sop && qw_cnt != '0) errSop_out <= 1'b1;
                        if (own_eop) begin
                            state     <= S_IDLE;
                            grant_out <= '0;
                            qw_cnt    <= '0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
